// File: rtl/mem_array_reader.sv
// -----------------------------------------------------------------------------
// mem_array_reader
//
// Purpose:
//   Read-out engine for the data-memory port. Once the CPU has halted, a start
//   pulse hands the memory port to this block. It reads word_count consecutive
//   32-bit words from base_addr and streams each word out over a valid/ready
//   interface, tagged with its index in the array.
//
// Optional build macro:
//   MEM_ARRAY_READER_SORT_CHECK_EN
//     Defined   : every accepted word after the first is compared, as a signed
//                 32-bit value, against the previously accepted word. A
//                 descending step clears sorted_ok until the next start.
//     Undefined : no comparator or previous-word register exists and
//                 sorted_ok is tied high.
//
// Parameters:
//   CNT_W    width of word_count and out_index
//   MEM_LAT  cycles from mem_read assertion to mem_rdata being captured
//            (1..4). With MEM_LAT=1 the word is captured on the edge that
//            ends the request cycle.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle pulse, begins a read-out when idle
//   base_addr   in   byte address of word 0, sampled on start
//   word_count  in   number of words to read, sampled on start
//   mem_addr    out  data-memory byte address
//   mem_read    out  data-memory read strobe, one cycle per word
//   mem_write   out  data-memory write enable, always 2'b00
//   mem_rdata   in   data-memory read data
//   out_data    out  word read
//   out_index   out  index of out_data within the array
//   out_valid   out  out_data/out_index valid
//   out_ready   in   sink accepts the word when out_valid && out_ready
//   busy        out  read-out in progress; CPU is muxed off memory while high
//   done        out  one-cycle pulse after the last word is accepted
//   sorted_ok   out  ascending-order check result
// -----------------------------------------------------------------------------
module mem_array_reader #(
  parameter int CNT_W   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic [1:0]       mem_write,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             sorted_ok
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // WAIT lasts MEM_LAT-1 cycles. For MEM_LAT=1 the WAIT state is bypassed
  // entirely and REQ goes straight to HOLD; WAIT_CYCLES is clamped to 1 only
  // so the terminal count below stays a legal constant.
  localparam int               WAIT_CYCLES = (MEM_LAT > 1) ? (MEM_LAT - 1) : 1;
  localparam logic [1:0]       LAT_LAST    = 2'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDX_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;
  logic [1:0]       r_lat_cnt;
  logic [31:0]      r_mem_addr;
  logic             r_mem_read;
  logic [31:0]      r_out_data;
  logic [CNT_W-1:0] r_out_index;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic w_start_accept;
  logic w_accept;
  logic w_last;
  logic w_capture;

  assign w_start_accept = (r_state == S_IDLE) && start;
  assign w_accept       = (r_state == S_HOLD) && out_ready;
  assign w_last         = (r_idx == (r_count - IDX_ONE));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (word_count == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        w_state_next = (MEM_LAT == 1) ? S_HOLD : S_WAIT;
      end
      S_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_next = w_last ? S_FIN : S_REQ;
        end
      end
      S_FIN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The read word is valid on the last cycle before HOLD, whether that cycle
  // is REQ (MEM_LAT=1) or the final WAIT cycle.
  assign w_capture = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                     (w_state_next == S_HOLD);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_lat_cnt   <= '0;
      r_mem_addr  <= '0;
      r_mem_read  <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Strobe is registered from the next state so it is high exactly for
      // the REQ cycle, alongside the address loaded on the same edge.
      r_mem_read <= (w_state_next == S_REQ);

      // done follows the FIN state by one edge, which is also the edge that
      // drops busy: the CPU regains the port as done fires.
      r_done <= (r_state == S_FIN);

      if (w_start_accept) begin
        r_mem_addr <= base_addr;
        r_count    <= word_count;
        r_idx      <= '0;
        r_busy     <= 1'b1;
      end

      if (r_state == S_REQ) begin
        r_lat_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt + 2'd1;
      end

      if (w_capture) begin
        r_out_data  <= mem_rdata;
        r_out_index <= r_idx;
        r_out_valid <= 1'b1;
      end

      // Address advances by one word per accepted word; 32-bit addition wraps
      // past 0xFFFFFFFC naturally. The index stops at word_count-1 so the
      // largest count never wraps it.
      if (w_accept) begin
        r_out_valid <= 1'b0;
        if (!w_last) begin
          r_idx      <= r_idx + IDX_ONE;
          r_mem_addr <= r_mem_addr + 32'd4;
        end
      end

      if (r_state == S_FIN) begin
        r_busy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ascending-order check
  // ---------------------------------------------------------------------------
`ifdef MEM_ARRAY_READER_SORT_CHECK_EN
  logic [31:0] r_prev_data;
  logic        r_sorted_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_data <= '0;
      r_sorted_ok <= 1'b1;
    end else if (w_start_accept) begin
      r_sorted_ok <= 1'b1;
    end else if (w_accept) begin
      r_prev_data <= r_out_data;
      // Equal neighbours are accepted; only a strict descent fails.
      if ((r_out_index != '0) && ($signed(r_out_data) < $signed(r_prev_data))) begin
        r_sorted_ok <= 1'b0;
      end
    end
  end

  assign sorted_ok = r_sorted_ok;
`else
  assign sorted_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_addr  = r_mem_addr;
  assign mem_read  = r_mem_read;
  assign mem_write = 2'b00;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_array_reader.sv
// -----------------------------------------------------------------------------
// tb_mem_array_reader
//
// Scoreboard bench for mem_array_reader. Two instances are built: one with
// MEM_LAT=1 (main tests) and one with MEM_LAT=3 (address-wrap / latency run).
// Stimulus pushes expected (index, data) pairs and expected read addresses
// into queues; free-running monitors pop and compare whenever the DUT reads
// memory or completes an output handshake.
// -----------------------------------------------------------------------------
module tb_mem_array_reader;

  localparam int CNT_W = 16;

`ifdef MEM_ARRAY_READER_SORT_CHECK_EN
  localparam bit SORT_EN = 1'b1;
`else
  localparam bit SORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             start3 = 1'b0;
  logic [31:0]      base_addr = 32'd0;
  logic [CNT_W-1:0] word_count = '0;
  logic             out_ready = 1'b1;

  // MEM_LAT=1 instance
  logic [31:0]      mem_addr, mem_rdata, out_data;
  logic             mem_read, out_valid, busy, done, sorted_ok;
  logic [1:0]       mem_write;
  logic [CNT_W-1:0] out_index;

  // MEM_LAT=3 instance
  logic [31:0]      mem_addr3, mem_rdata3, out_data3;
  logic             mem_read3, out_valid3, busy3, done3, sorted_ok3;
  logic [1:0]       mem_write3;
  logic [CNT_W-1:0] out_index3;

  mem_array_reader #(.CNT_W(CNT_W), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .sorted_ok(sorted_ok)
  );

  mem_array_reader #(.CNT_W(CNT_W), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .base_addr(base_addr), .word_count(word_count),
    .mem_addr(mem_addr3), .mem_read(mem_read3), .mem_write(mem_write3), .mem_rdata(mem_rdata3),
    .out_data(out_data3), .out_index(out_index3), .out_valid(out_valid3), .out_ready(out_ready),
    .busy(busy3), .done(done3), .sorted_ok(sorted_ok3)
  );

  // ---------------------------------------------------------------------------
  // Memory model: word array indexed by addr[11:2]. Data is only presented in
  // the cycle it is due; any other cycle shows a poison value.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:1023];

  assign mem_rdata = mem_read ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_a = 32'd0, s2_a = 32'd0;
  always @(posedge clk) begin
    s1_v <= mem_read3;
    s1_a <= mem_addr3;
    s2_v <= s1_v;
    s2_a <= s1_a;
  end
  assign mem_rdata3 = s2_v ? mem[s2_a[11:2]] : 32'hDEAD_BEEF;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [CNT_W-1:0] idx;
    logic [31:0]      data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp3_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] addr3_q[$];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0, rd_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int hs3_cnt = 0, rd3_cnt = 0, done3_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    mem[a[11:2]] = d;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor for the MEM_LAT=1 instance
  // ---------------------------------------------------------------------------
  initial begin : mon1
    logic             prev_mr, prev_stall, prev_done;
    logic [31:0]      prev_data;
    logic [CNT_W-1:0] prev_idx;
    exp_t             e;
    prev_mr = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
    prev_data = '0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_mr = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
      end else begin
        if (mem_read) begin
          rd_cnt++;
          chk("mem_read_one_cycle", prev_mr, 0);
          chk("mem_write_zero", mem_write, 0);
          if (addr_q.size() == 0) chk("spurious_mem_read", mem_read, 0);
          else chk("mem_addr", mem_addr, addr_q.pop_front());
        end
        if (out_valid) valid_cnt++;
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
          chk("hold_index", out_index, prev_idx);
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) chk("spurious_handshake", out_valid, 0);
          else begin
            e = exp_q.pop_front();
            $display("hs1 idx=%0d data=0x%08h exp_idx=%0d exp_data=0x%08h", out_index, out_data, e.idx, e.data);
            chk("out_index", out_index, e.idx);
            chk("out_data", out_data, e.data);
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_low_at_done", busy, 0);
          chk("done_one_cycle", prev_done, 0);
        end
        prev_mr    = mem_read;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_index;
        prev_done  = done;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor for the MEM_LAT=3 instance (also measures read-to-valid latency)
  // ---------------------------------------------------------------------------
  initial begin : mon3
    int   cyc3, rd_cyc;
    logic prev_v;
    exp_t e;
    cyc3 = 0; rd_cyc = 0; prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc3++;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (mem_read3) begin
          rd3_cnt++;
          rd_cyc = cyc3;
          if (addr3_q.size() == 0) chk("spurious_mem_read3", mem_read3, 0);
          else chk("mem_addr3", mem_addr3, addr3_q.pop_front());
        end
        if (out_valid3 && !prev_v) chk("lat3_read_to_valid", 64'(cyc3 - rd_cyc), 3);
        if (out_valid3 && out_ready) begin
          hs3_cnt++;
          if (exp3_q.size() == 0) chk("spurious_handshake3", out_valid3, 0);
          else begin
            e = exp3_q.pop_front();
            $display("hs3 idx=%0d data=0x%08h exp_idx=%0d exp_data=0x%08h", out_index3, out_data3, e.idx, e.data);
            chk("out_index3", out_index3, e.idx);
            chk("out_data3", out_data3, e.data);
          end
        end
        if (done3) begin
          done3_cnt++;
          chk("busy3_low_at_done", busy3, 0);
        end
        prev_v = out_valid3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic queue_words(input logic [31:0] base, input int n, input bit use3);
    logic [31:0] a;
    exp_t        e;
    for (int i = 0; i < n; i++) begin
      a      = base + 32'(4 * i);
      e.idx  = CNT_W'(i);
      e.data = mem[a[11:2]];
      if (use3) begin exp3_q.push_back(e); addr3_q.push_back(a); end
      else      begin exp_q.push_back(e);  addr_q.push_back(a);  end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sorted_ok"}, sorted_ok, 1);
  endtask

  // Full read-out: optional pseudo-random backpressure (bp) and an ignored
  // start pulse with different base/count injected mid-run (poke).
  task automatic run(input logic [31:0] base, input int n, input bit bp, input bit poke,
                     input bit use3, input bit exp_sorted, input string tag);
    int          hs0, rd0, dn0, cyc;
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    hs0  = use3 ? hs3_cnt : hs_cnt;
    rd0  = use3 ? rd3_cnt : rd_cnt;
    dn0  = use3 ? done3_cnt : done_cnt;
    queue_words(base, n, use3);
    @(posedge clk); #1;
    base_addr  = base;
    word_count = CNT_W'(n);
    out_ready  = 1'b1;
    if (use3) start3 = 1'b1; else start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start  = 1'b0;
      start3 = 1'b0;
      cyc++;
      if (cyc == 1) chk({tag, "_busy_high"}, use3 ? busy3 : busy, 1);
      if (bp) begin
        lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        out_ready = lfsr[0];
      end
      if (poke && cyc == 4) begin
        base_addr  = 32'h0000_0040;
        word_count = CNT_W'(2);
        start      = 1'b1;
      end
    end while (((use3 ? done3_cnt : done_cnt) == dn0) && cyc < 3000);
    out_ready = 1'b1;
    chk({tag, "_no_timeout"}, cyc < 3000, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_handshakes"}, 64'((use3 ? hs3_cnt : hs_cnt) - hs0), 64'(n));
    chk({tag, "_mem_reads"}, 64'((use3 ? rd3_cnt : rd_cnt) - rd0), 64'(n));
    chk({tag, "_done_pulses"}, 64'((use3 ? done3_cnt : done_cnt) - dn0), 1);
    chk({tag, "_sorted_ok"}, use3 ? sorted_ok3 : sorted_ok, exp_sorted);
    chk({tag, "_queue_drained"}, 64'(use3 ? exp3_q.size() : exp_q.size()), 0);
    $display("run %s words=%0d done", tag, n);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int dn0, rd0, vc0, hs0, cyc;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    chk("por_busy3", busy3, 0);
    chk("por_valid3", out_valid3, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1) unsorted array: 5, 3, 9
    put(32'h10F0, 32'd5); put(32'h10F4, 32'd3); put(32'h10F8, 32'd9);
    run(32'h0000_10F0, 3, 1'b0, 1'b0, 1'b0, !SORT_EN, "unsorted");

    // 2) equal neighbours pass: 3, 5, 9, 9
    put(32'h10F0, 32'd3); put(32'h10F4, 32'd5); put(32'h10F8, 32'd9); put(32'h10FC, 32'd9);
    run(32'h0000_10F0, 4, 1'b0, 1'b0, 1'b0, 1'b1, "equal");

    // 2b) signed compare: -2, -1, 0
    put(32'h1400, 32'hFFFF_FFFE); put(32'h1404, 32'hFFFF_FFFF); put(32'h1408, 32'h0000_0000);
    run(32'h0000_1400, 3, 1'b0, 1'b0, 1'b0, 1'b1, "signed");

    // 3) backpressure over 8 ascending words with an ignored mid-run start
    for (int i = 0; i < 8; i++) put(32'h3200 + 32'(4 * i), 32'(100 + 7 * i));
    run(32'h0000_3200, 8, 1'b1, 1'b1, 1'b0, 1'b1, "backpressure");

    // 4) count = 0: done two cycles after start, no reads, no valid
    rd0 = rd_cnt; vc0 = valid_cnt; dn0 = done_cnt;
    @(posedge clk); #1;
    base_addr = 32'h0000_0500; word_count = '0; start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("cnt0_done_cycle1", done, 0);
    chk("cnt0_busy_cycle1", busy, 1);
    @(negedge clk);
    chk("cnt0_done_cycle2", done, 1);
    chk("cnt0_busy_cycle2", busy, 0);
    repeat (3) @(negedge clk);
    chk("cnt0_no_reads", 64'(rd_cnt - rd0), 0);
    chk("cnt0_no_valid", 64'(valid_cnt - vc0), 0);
    chk("cnt0_one_done", 64'(done_cnt - dn0), 1);
    $display("run cnt0 done");

    // 5) reset while holding word 1 of 4
    put(32'h2100, 32'd10); put(32'h2104, 32'd20); put(32'h2108, 32'd30); put(32'h210C, 32'd40);
    queue_words(32'h0000_2100, 4, 1'b0);
    dn0 = done_cnt; hs0 = hs_cnt;
    @(posedge clk); #1;
    base_addr = 32'h0000_2100; word_count = CNT_W'(4); out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_index == CNT_W'(1)) && cyc < 100) begin
      out_ready = out_valid && (out_index == '0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_reached_hold1", cyc < 100, 1);
    chk("rst_word0_accepted", 64'(hs_cnt - hs0), 1);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt - dn0), 0);
    out_ready = 1'b1;
    run(32'h0000_2100, 4, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst");

    // 6) address wrap on both latencies: 1, 2, 3 from 0xFFFFFFF8
    put(32'hFFFF_FFF8, 32'd1); put(32'hFFFF_FFFC, 32'd2); put(32'h0000_0000, 32'd3);
    run(32'hFFFF_FFF8, 3, 1'b0, 1'b0, 1'b0, 1'b1, "wrap_lat1");
    run(32'hFFFF_FFF8, 3, 1'b0, 1'b0, 1'b1, 1'b1, "wrap_lat3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
